// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each requester gets a registered result on its own valid/ready response channel.
//
// state | meaning
// IDLE  | waiting for a request; grant round-robin, latch operands on handshake
// EXEC  | ALU driven from the issue registers; capture result at end of cycle
// RESP  | owner's response valid; wait for the owner's ready
module alu_share_arbiter #(
   parameter int DATA_W = 32,
   parameter int OPT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_oprd1,
   input  logic [DATA_W-1:0] req0_oprd2,
   input  logic [OPT_W-1:0]  req0_option,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_oprd1,
   input  logic [DATA_W-1:0] req1_oprd2,
   input  logic [OPT_W-1:0]  req1_option,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_zero,
   output logic              rsp0_err,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_zero,
   output logic              rsp1_err,
   output logic [DATA_W-1:0] alu_oprd1,
   output logic [DATA_W-1:0] alu_oprd2,
   output logic [OPT_W-1:0]  alu_option,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [OPT_W-1:0] OPT_DIV  = OPT_W'(4'b1001);
   localparam logic [OPT_W-1:0] OPT_BAD0 = OPT_W'(4'b1011);
   localparam logic [OPT_W-1:0] OPT_BAD1 = OPT_W'(4'b1101);
   localparam logic [OPT_W-1:0] OPT_BAD2 = OPT_W'(4'b1110);

   state_t state, state_nxt;
   logic   last_grant;
   logic   owner;
   logic   grant;
   logic   req_hs;
   logic   rsp_hs;
   logic   err_now;

   // Contention goes to whoever did not win last; a lone request always wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid)
         grant = ~last_grant;
      else if (req1_valid)
         grant = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      req_hs     = 1'b0;
      rsp_hs     = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = req0_valid & ~grant;
            req1_ready = req1_valid & grant;
            req_hs     = (req0_valid & ~grant) | (req1_valid & grant);
            if (req_hs)
               state_nxt = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_hs = owner ? rsp1_ready : rsp0_ready;
            if (rsp_hs)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign err_now = ((alu_option == OPT_DIV) && (alu_oprd2 == '0)) ||
                    (alu_option inside {OPT_BAD0, OPT_BAD1, OPT_BAD2});

   // The alu_* outputs double as the issue registers, so they hold between ops.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant  <= 1'b1;
         owner       <= 1'b0;
         alu_oprd1   <= '0;
         alu_oprd2   <= '0;
         alu_option  <= '0;
         rsp0_valid  <= 1'b0;
         rsp0_result <= '0;
         rsp0_zero   <= 1'b0;
         rsp0_err    <= 1'b0;
         rsp1_valid  <= 1'b0;
         rsp1_result <= '0;
         rsp1_zero   <= 1'b0;
         rsp1_err    <= 1'b0;
      end else begin
         if (state == IDLE && req_hs) begin
            owner      <= grant;
            last_grant <= grant;
            alu_oprd1  <= grant ? req1_oprd1  : req0_oprd1;
            alu_oprd2  <= grant ? req1_oprd2  : req0_oprd2;
            alu_option <= grant ? req1_option : req0_option;
         end
         if (state == EXEC) begin
            if (owner) begin
               rsp1_valid  <= 1'b1;
               rsp1_result <= err_now ? '0 : alu_result;
               rsp1_zero   <= err_now | alu_zero;
               rsp1_err    <= err_now;
            end else begin
               rsp0_valid  <= 1'b1;
               rsp0_result <= err_now ? '0 : alu_result;
               rsp0_zero   <= err_now | alu_zero;
               rsp0_err    <= err_now;
            end
         end
         if (rsp_hs) begin
            if (owner)
               rsp1_valid <= 1'b0;
            else
               rsp0_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table with a small ALU model,
// plus hand sequences for contention, backpressure and reset during EXEC.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_oprd1, req0_oprd2, req1_oprd1, req1_oprd2;
   logic [3:0]  req0_option, req1_option;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [31:0] rsp0_result, rsp1_result;
   logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
   logic [31:0] alu_oprd1, alu_oprd2, alu_result;
   logic [3:0]  alu_option;
   logic        alu_zero;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.DATA_W(32), .OPT_W(4)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_oprd1(req0_oprd1), .req0_oprd2(req0_oprd2), .req0_option(req0_option),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_oprd1(req1_oprd1), .req1_oprd2(req1_oprd2), .req1_option(req1_option),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
      .alu_oprd1(alu_oprd1), .alu_oprd2(alu_oprd2), .alu_option(alu_option),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   // Stand-in ALU; unsupported codes return junk so the arbiter must mask them.
   always_comb begin
      case (alu_option)
         4'b0000: alu_result = alu_oprd1 & alu_oprd2;
         4'b0001: alu_result = alu_oprd1 | alu_oprd2;
         4'b0010: alu_result = alu_oprd1 + alu_oprd2;
         4'b0110: alu_result = alu_oprd1 - alu_oprd2;
         4'b1001: alu_result = (alu_oprd2 == 32'd0) ? 32'hFFFF_FFFF : alu_oprd1 / alu_oprd2;
         default: alu_result = 32'hDEAD_BEEF;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   typedef struct {
      logic        who;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  opt;
      logic [31:0] res;
      logic        zero;
      logic        err;
   } vec_t;

   localparam int NV = 10;
   vec_t vec [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0;
      req0_oprd1 = 0; req0_oprd2 = 0; req0_option = 0;
      req1_oprd1 = 0; req1_oprd2 = 0; req1_option = 0;
      rsp0_ready = 1; rsp1_ready = 1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      cyc();
      cyc();
      reset = 0;
   endtask

   initial begin
      vec[0] = '{1'b0, 32'd5,          32'd7,          4'b0010, 32'd12,         1'b0, 1'b0};
      vec[1] = '{1'b1, 32'd10,         32'd0,          4'b1001, 32'd0,          1'b1, 1'b1};
      vec[2] = '{1'b1, 32'd10,         32'd3,          4'b1001, 32'd3,          1'b0, 1'b0};
      vec[3] = '{1'b1, 32'd4,          32'd5,          4'b1011, 32'd0,          1'b1, 1'b1};
      vec[4] = '{1'b0, 32'd3,          32'd3,          4'b0110, 32'd0,          1'b1, 1'b0};
      vec[5] = '{1'b0, 32'h0000_00F0,  32'h0000_000F,  4'b0001, 32'h0000_00FF,  1'b0, 1'b0};
      vec[6] = '{1'b1, 32'd8,          32'd1,          4'b1101, 32'd0,          1'b1, 1'b1};
      vec[7] = '{1'b0, 32'd8,          32'd1,          4'b1110, 32'd0,          1'b1, 1'b1};
      vec[8] = '{1'b1, 32'hFFFF_0000,  32'h0F0F_0F0F,  4'b0000, 32'h0F0F_0000,  1'b0, 1'b0};
      vec[9] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          4'b0010, 32'd0,          1'b1, 1'b0};

      do_reset();
      chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
      chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
      chk ("rst_rsp0_result", rsp0_result, 32'd0);
      chk1("rst_rsp1_zero", rsp1_zero, 1'b0);
      chk1("rst_rsp0_err", rsp0_err, 1'b0);
      chk ("rst_alu_oprd1", alu_oprd1, 32'd0);
      chk ("rst_alu_option", {28'd0, alu_option}, 32'd0);

      // Single-requester ops with exact 3-cycle latency checks.
      for (int i = 0; i < NV; i++) begin
         req0_valid = ~vec[i].who; req1_valid = vec[i].who;
         req0_oprd1 = vec[i].a; req0_oprd2 = vec[i].b; req0_option = vec[i].opt;
         req1_oprd1 = vec[i].a; req1_oprd2 = vec[i].b; req1_option = vec[i].opt;
         #1;
         chk1($sformatf("v%0d_accept_ready", i), vec[i].who ? req1_ready : req0_ready, 1'b1);
         cyc();
         chk1($sformatf("v%0d_exec_ready", i), vec[i].who ? req1_ready : req0_ready, 1'b0);
         chk1($sformatf("v%0d_exec_valid", i), vec[i].who ? rsp1_valid : rsp0_valid, 1'b0);
         chk ($sformatf("v%0d_alu_oprd1", i), alu_oprd1, vec[i].a);
         chk ($sformatf("v%0d_alu_oprd2", i), alu_oprd2, vec[i].b);
         chk ($sformatf("v%0d_alu_option", i), {28'd0, alu_option}, {28'd0, vec[i].opt});
         cyc();
         chk1($sformatf("v%0d_rsp_valid", i), vec[i].who ? rsp1_valid : rsp0_valid, 1'b1);
         chk1($sformatf("v%0d_other_valid", i), vec[i].who ? rsp0_valid : rsp1_valid, 1'b0);
         chk ($sformatf("v%0d_result", i), vec[i].who ? rsp1_result : rsp0_result, vec[i].res);
         chk1($sformatf("v%0d_zero", i), vec[i].who ? rsp1_zero : rsp0_zero, vec[i].zero);
         chk1($sformatf("v%0d_err", i), vec[i].who ? rsp1_err : rsp0_err, vec[i].err);
         chk1($sformatf("v%0d_resp_ready", i), vec[i].who ? req1_ready : req0_ready, 1'b0);
         cyc();
         chk1($sformatf("v%0d_valid_cleared", i), vec[i].who ? rsp1_valid : rsp0_valid, 1'b0);
         req0_valid = 0; req1_valid = 0;
      end

      // Contention after reset: req0 first, then req1, then req0 again.
      do_reset();
      req0_valid = 1; req0_oprd1 = 3; req0_oprd2 = 3; req0_option = 4'b0110;
      req1_valid = 1; req1_oprd1 = 32'hF0; req1_oprd2 = 32'h0F; req1_option = 4'b0001;
      #1;
      chk1("c1_req0_ready", req0_ready, 1'b1);
      chk1("c1_req1_ready", req1_ready, 1'b0);
      cyc();
      req0_valid = 0;
      #1;
      chk1("c1_exec_req1_ready", req1_ready, 1'b0);
      cyc();
      chk1("c1_rsp0_valid", rsp0_valid, 1'b1);
      chk ("c1_rsp0_result", rsp0_result, 32'd0);
      chk1("c1_rsp0_zero", rsp0_zero, 1'b1);
      chk1("c1_resp_req1_ready", req1_ready, 1'b0);
      cyc();
      chk1("c2_req1_ready", req1_ready, 1'b1);
      chk1("c2_rsp0_cleared", rsp0_valid, 1'b0);
      cyc();
      req1_valid = 0;
      cyc();
      chk1("c2_rsp1_valid", rsp1_valid, 1'b1);
      chk ("c2_rsp1_result", rsp1_result, 32'hFF);
      chk1("c2_rsp1_zero", rsp1_zero, 1'b0);
      cyc();
      req0_valid = 1; req0_oprd1 = 1; req0_oprd2 = 1; req0_option = 4'b0010;
      req1_valid = 1; req1_oprd1 = 2; req1_oprd2 = 2; req1_option = 4'b0010;
      #1;
      chk1("c3_req0_ready", req0_ready, 1'b1);
      chk1("c3_req1_ready", req1_ready, 1'b0);
      cyc();
      req0_valid = 0; req1_valid = 0;
      cyc();
      chk1("c3_rsp0_valid", rsp0_valid, 1'b1);
      chk ("c3_rsp0_result", rsp0_result, 32'd2);
      cyc();

      // Backpressure on rsp0 while req1 waits.
      req0_valid = 1; req0_oprd1 = 20; req0_oprd2 = 22; req0_option = 4'b0010;
      rsp0_ready = 0;
      #1;
      chk1("bp_req0_ready", req0_ready, 1'b1);
      cyc();
      req0_valid = 0;
      req1_valid = 1; req1_oprd1 = 100; req1_oprd2 = 1; req1_option = 4'b0010;
      #1;
      chk1("bp_exec_req1_ready", req1_ready, 1'b0);
      cyc();
      for (int k = 0; k < 5; k++) begin
         chk1($sformatf("bp%0d_rsp0_valid", k), rsp0_valid, 1'b1);
         chk ($sformatf("bp%0d_rsp0_result", k), rsp0_result, 32'd42);
         chk1($sformatf("bp%0d_req1_ready", k), req1_ready, 1'b0);
         cyc();
      end
      rsp0_ready = 1;
      #1;
      chk1("bp_hs_rsp0_valid", rsp0_valid, 1'b1);
      chk1("bp_hs_req1_ready", req1_ready, 1'b0);
      cyc();
      chk1("bp_after_rsp0_valid", rsp0_valid, 1'b0);
      chk1("bp_after_req1_ready", req1_ready, 1'b1);
      cyc();
      req1_valid = 0;
      cyc();
      chk1("bp_rsp1_valid", rsp1_valid, 1'b1);
      chk ("bp_rsp1_result", rsp1_result, 32'd101);
      cyc();

      // Reset during EXEC discards the op and restores round-robin priority.
      req0_valid = 1; req0_oprd1 = 9; req0_oprd2 = 9; req0_option = 4'b0010;
      #1;
      chk1("rx_req0_ready", req0_ready, 1'b1);
      cyc();
      req0_valid = 0;
      reset = 1;
      cyc();
      reset = 0;
      #1;
      chk ("rx_alu_oprd1", alu_oprd1, 32'd0);
      chk ("rx_alu_oprd2", alu_oprd2, 32'd0);
      chk ("rx_alu_option", {28'd0, alu_option}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         chk1($sformatf("rx%0d_rsp0_valid", k), rsp0_valid, 1'b0);
         chk1($sformatf("rx%0d_rsp1_valid", k), rsp1_valid, 1'b0);
         cyc();
      end
      req0_valid = 1; req1_valid = 1;
      #1;
      chk1("rx_req0_ready", req0_ready, 1'b1);
      chk1("rx_req1_ready", req1_ready, 1'b0);
      cyc();
      req0_valid = 0; req1_valid = 0;
      cyc();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational ALU between two requesters, e.g. the main pipeline execute stage and a secondary unit such as a branch/address helper. Each requester presents operands and a 4-bit ALU option on a valid/ready request channel and gets a registered result on a valid/ready response channel. Arbitration is round-robin. The block drives the ALU inputs, captures `result`/`zero`, and flags divide-by-zero and unsupported options.

Parameters:
DATA_W, 32, operand/result width (matches ALU)
OPT_W, 4, ALU option width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req0_valid / req1_valid  input  1  request valid per requester
req0_ready / req1_ready  output  1  request accepted this cycle (combinational)
req0_oprd1 / req1_oprd1  input  DATA_W  first operand
req0_oprd2 / req1_oprd2  input  DATA_W  second operand
req0_option / req1_option  input  OPT_W  ALU operation code
rsp0_valid / rsp1_valid  output  1  response valid per requester
rsp0_ready / rsp1_ready  input  1  requester accepts response
rsp0_result / rsp1_result  output  DATA_W  registered ALU result
rsp0_zero / rsp1_zero  output  1  registered zero flag
rsp0_err / rsp1_err  output  1  divide-by-zero or unsupported option
alu_oprd1, alu_oprd2  output  DATA_W  to ALU operands
alu_option  output  OPT_W  to ALU option
alu_result  input  DATA_W  from ALU
alu_zero  input  1  from ALU

Behaviour:
- Single clock `clk`. `reset` is synchronous and active-high.
- Reset values:
  - FSM = IDLE, last_grant = 1, so requester 0 wins the first contention.
  - All rsp*_valid/result/zero/err = 0.
  - alu_oprd1/alu_oprd2/alu_option = 0.
  - Owner register = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection: if exactly one req valid, grant it. If both are valid, grant the one != last_grant.
  - reqN_ready = (state==IDLE) & reqN_valid & (grant==N). ready may depend on the other requester's valid.
  - On handshake: latch oprd1/oprd2/option into issue registers, set owner=N, set last_grant=N, go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_* outputs are driven from the issue registers. They are registered, so they update on the accept edge.
  - At the end of EXEC, capture into the owner's response registers:
    - err = (option==4'b1001 & oprd2==0) | option in {4'b1011, 4'b1101, 4'b1110}
    - if err: result=0, zero=1
    - else: result=alu_result, zero=alu_zero
  - Go to RESP.
- RESP:
  - rsp[owner]_valid=1. result/zero/err are held stable until rsp[owner]_ready=1.
  - On handshake, clear valid and go to IDLE.
  - No new request is accepted in the handshake cycle.
- alu_* hold their last issued values outside EXEC.
- The non-owner's rsp valid/result/zero/err hold their previous values; valid stays 0.
- Latency: request accepted at edge N, rspN_valid high from cycle N+2. Peak throughput is 1 op per 3 cycles.
- last_grant updates only on request handshake, never on response.
- Requesters must hold operands/option stable while valid & !ready. The block does not check this.
- reset in any state, including EXEC/RESP: the in-flight op is discarded and no response is issued. The next cycle is IDLE with reset values.
- Widths: no extension or truncation. The result is the ALU's DATA_W-bit output unmodified.

Test Plan:
1. req0 ADD (option 0010) 5+7, accepted at cycle N, rsp0_ready=1 -> rsp0_valid only in cycle N+2; result=12, zero=0, err=0; req0_ready low in cycles N+1..N+2.
2. After reset, both valid the same cycle: req0 SUB 3-3, req1 OR 0xF0|0x0F -> req0 granted first (result 0, zero 1). req1 granted next (result 0xFF). A third simultaneous pair goes to req0 (alternation).
3. req1 DIV 10/0 (option 1001) -> rsp1_result=0, zero=1, err=1. Then DIV 10/3 -> result=3, err=0. Option 1011 -> err=1, result=0.
4. Backpressure: rsp0_ready held low 5 cycles with req1_valid high throughout -> rsp0_valid and result stable. req1_ready asserts only in the cycle after the rsp0 handshake.
5. reset asserted during EXEC of a req0 ADD -> next cycle rsp0_valid=0, alu_* = 0, FSM IDLE. No response appears afterward; req0 is granted first on subsequent contention.
